// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: first-word-fall-through AXI-Stream sample buffer between the Wishbone stream-write path and the FIR ss_* input
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   flush                       : synchronous clear of contents (pointers, count, last_seen)
//   s_tvalid/s_tdata/s_tlast    : upstream beat, accepted when s_tready
//   m_tvalid/m_tdata/m_tlast    : head entry, popped when m_tready
//   level, empty, full          : occupancy from the registered count
//   almost_full                 : level >= HI_WATER
//   last_seen                   : sticky, a tlast entry was popped since reset/flush
module axis_sample_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int HI_WATER   = 6,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  flush,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic                  m_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic [AW:0]           level,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  last_seen
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] HI_LVL   = (AW+1)'(HI_WATER);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                push;
    logic                pop;

    assign level       = count;
    assign empty       = count == '0;
    assign full        = count == FULL_LVL;
    assign almost_full = count >= HI_LVL;
    // No full-bypass: a pop in the full cycle does not free a slot until the next edge.
    assign s_tready    = !full && !wb_rst_i && !flush;
    assign m_tvalid    = !empty;
    assign {m_tlast, m_tdata} = mem[rd_ptr];
    assign push        = s_tvalid && s_tready;
    assign pop         = m_tvalid && m_tready;

    // Storage is never cleared; s_tready already blocks writes during reset/flush.
    always_ff @(posedge wb_clk_i) begin
        if (push)
            mem[wr_ptr] <= {s_tlast, s_tdata};
    end

    // Flush shares the reset path and overrides any pop handshake in the same cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_seen <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (pop && m_tlast)
                last_seen <= 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    a_no_overflow: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i || flush)
        !(push && count == FULL_LVL));
    a_no_underflow: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i || flush)
        !(pop && count == '0));
endmodule

// File: tb/tb_axis_sample_fifo.sv
// tb_axis_sample_fifo: directed vector table plus fill/drain sequence for axis_sample_fifo
module tb_axis_sample_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [3:0]  level;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        last_seen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axis_sample_fifo dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .flush      (flush),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .last_seen  (last_seen)
    );

    // Inputs applied before an edge; expected outputs are the state after that edge with inputs still held.
    typedef struct {
        logic        rst, fl, sv;
        logic [31:0] sd;
        logic        sl, mr;
        int          lvl;
        logic [31:0] md;
        logic        ml, ls;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, f, sv, input logic [31:0] sd, input logic sl, mr,
                       input int lvl, input logic [31:0] md, input logic ml, ls);
        vec_t v;
        v.rst = r; v.fl = f; v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
        v.lvl = lvl; v.md = md; v.ml = ml; v.ls = ls;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        int n;
        int k;
        logic acc;
        rst = 1'b1; flush = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;

        // reset with a beat offered, then three pushes held at the head
        add(1, 0, 1, 32'hDEAD, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 32'h11, 0, 0, 1, 32'h11, 0, 0);
        add(0, 0, 1, 32'h22, 0, 0, 2, 32'h11, 0, 0);
        add(0, 0, 1, 32'h33, 0, 0, 3, 32'h11, 0, 0);
        add(0, 0, 0, 0, 0, 0, 3, 32'h11, 0, 0);
        add(0, 0, 0, 0, 0, 1, 2, 32'h22, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 32'h33, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // fill to full, then pop while full with 0x108 offered
        for (int i = 0; i < 8; i++) add(0, 0, 1, 32'h100 + i, 0, 0, i + 1, 32'h100, 0, 0);
        add(0, 0, 1, 32'h108, 0, 1, 7, 32'h101, 0, 0);
        add(0, 0, 1, 32'h108, 0, 0, 8, 32'h101, 0, 0);
        for (int j = 1; j <= 8; j++) add(0, 0, 0, 0, 0, 1, 8 - j, 32'h101 + j, 0, 0);
        // streaming at level 1 across pointer wrap
        add(0, 0, 1, 32'h200, 0, 0, 1, 32'h200, 0, 0);
        for (int i = 1; i <= 20; i++) add(0, 0, 1, 32'h200 + i, 0, 1, 1, 32'h200 + i, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // tlast pop sets last_seen
        add(0, 0, 1, 32'hAA, 1, 0, 1, 32'hAA, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // flush at level 5 with push and pop offered
        for (int i = 0; i < 5; i++) add(0, 0, 1, 32'h300 + i, 0, 0, i + 1, 32'h300, 0, 1);
        add(0, 1, 1, 32'hBEEF, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 32'h6, 0, 0, 1, 32'h6, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // mid-stream reset at level 4 after last_seen was set
        add(0, 0, 1, 32'h7, 1, 0, 1, 32'h7, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 32'h400 + i, 0, 0, i + 1, 32'h400, 0, 1);
        add(1, 0, 1, 32'h999, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 32'h5, 0, 0, 1, 32'h5, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; flush = vecs[i].fl; s_tvalid = vecs[i].sv;
            s_tdata = vecs[i].sd; s_tlast = vecs[i].sl; m_tready = vecs[i].mr;
            @(posedge clk);
            #1;
            chk("level", i, 32'(level), 32'(vecs[i].lvl));
            chk("m_tvalid", i, 32'(m_tvalid), 32'(vecs[i].lvl > 0));
            chk("empty", i, 32'(empty), 32'(vecs[i].lvl == 0));
            chk("full", i, 32'(full), 32'(vecs[i].lvl == 8));
            chk("almost_full", i, 32'(almost_full), 32'(vecs[i].lvl >= 6));
            chk("s_tready", i, 32'(s_tready), 32'(vecs[i].lvl < 8 && !vecs[i].rst && !vecs[i].fl));
            chk("last_seen", i, 32'(last_seen), 32'(vecs[i].ls));
            if (vecs[i].lvl > 0) begin
                chk("m_tdata", i, m_tdata, vecs[i].md);
                chk("m_tlast", i, 32'(m_tlast), 32'(vecs[i].ml));
            end
        end

        // fill until full under a cycle bound, then drain and check order
        rst = 1'b0; flush = 1'b0; s_tlast = 1'b0; m_tready = 1'b0; s_tvalid = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && !full; c++) begin
            s_tdata = 32'h500 + n;
            acc = s_tready;
            @(posedge clk);
            #1;
            if (acc) n++;
        end
        chk("fill_count", 900, n, 8);
        chk("fill_full", 901, 32'(full), 1);
        s_tvalid = 1'b0; m_tready = 1'b1;
        k = 0;
        for (int c = 0; c < 20 && m_tvalid; c++) begin
            chk("drain_data", 1000 + k, m_tdata, 32'h500 + k);
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_count", 902, k, 8);
        chk("drain_empty", 903, 32'(empty), 1);
        m_tready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
